// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Supplies a combinational next-PC prediction for the fetch PC and
// resolves branches from execute. On a misprediction it raises a
// same-cycle redirect (jump_en / pc_jump_addr) that also flushes the pipe.
//
// Execute-side contract: the ex_* bundle is sampled only when ex_valid is
// high. There is no back-pressure; every valid bundle is resolved and
// trained in the cycle it is presented. While rst is high the bundle is
// ignored entirely (no redirect, no table write, no statistics).

module btb_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,

    // fetch-side lookup
    input  logic [31:0] pc,
    output logic [31:0] btb_target_pc,
    output logic        btb_pc_valid,
    output logic        btb_pc_predictTaken,

    // execute-side resolution
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,

    // redirect to fetch
    output logic        jump_en,
    output logic [31:0] pc_jump_addr,

    // statistics
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TAG_W = 32 - IDX - 2;

    // Counter values used when allocating and after reset.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    // Word-offset bits of the PCs never select anything in the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[1:0], ex_pc[1:0]};

    // ------------------------------------------------------------------
    // Fetch lookup (combinational, reads pre-update contents)
    // ------------------------------------------------------------------
    logic [IDX-1:0]   fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    assign fetch_idx = pc[IDX+1:2];
    assign fetch_tag = pc[31:IDX+2];

    // Hit detection and prediction outputs; a miss falls through to pc+4.
    always_comb begin
        fetch_hit           = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        btb_pc_valid        = fetch_hit;
        btb_pc_predictTaken = fetch_hit && ctr_q[fetch_idx][1];
        btb_target_pc       = fetch_hit ? target_q[fetch_idx] : (pc + 32'd4);
    end

    // ------------------------------------------------------------------
    // Execute resolution (combinational)
    // ------------------------------------------------------------------
    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             ex_mispredict;
    logic             ex_active;

    assign ex_idx    = ex_pc[IDX+1:2];
    assign ex_tag    = ex_pc[31:IDX+2];
    assign ex_active = ex_valid && !rst;

    // Decide whether the fetch-time guess was wrong and where fetch must go.
    always_comb begin
        ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

        if (ex_is_branch) begin
            // Wrong direction, or right direction but wrong taken target.
            ex_mispredict = (ex_pred_taken != ex_taken) ||
                            (ex_taken && (ex_pred_target != ex_target));
        end else begin
            // A non-branch that was predicted taken hit a stale/aliased entry.
            ex_mispredict = ex_pred_taken;
        end

        jump_en      = ex_active && ex_mispredict;
        pc_jump_addr = 32'd0;
        if (jump_en) begin
            pc_jump_addr = (ex_is_branch && ex_taken) ? ex_target : (ex_pc + 32'd4);
        end
    end

    // ------------------------------------------------------------------
    // Table training
    // ------------------------------------------------------------------
    // Reset clears the table; otherwise train the entry addressed by ex_pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (ex_valid) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    if (ex_taken) begin
                        if (ctr_q[ex_idx] != CTR_MAX) begin
                            ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                        end
                        target_q[ex_idx] <= ex_target;
                    end else begin
                        if (ctr_q[ex_idx] != CTR_MIN) begin
                            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                        end
                    end
                end else if (ex_taken) begin
                    // Allocate over whatever occupied this slot, weakly taken.
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= ex_target;
                    ctr_q[ex_idx]    <= CTR_ALLOC;
                end
            end else if (ex_pred_taken && ex_hit) begin
                // Entry steered a non-branch; drop it so it stops redirecting.
                valid_q[ex_idx] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    // Free-running counters of resolved branches and issued redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (ex_valid && ex_is_branch) begin
                branch_count <= branch_count + 32'd1;
            end
            if (jump_en) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES = 16: index pc[5:2], tag pc[31:6]).
// Inputs change on the falling edge; outputs are checked 1ns later, well
// before the next rising edge where the table and counters update.

module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] btb_target_pc;
  logic        btb_pc_valid;
  logic        btb_pc_predictTaken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        jump_en;
  logic [31:0] pc_jump_addr;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_checks;
  int n_errors;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  btb_predictor #(.ENTRIES(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc                  (pc),
    .btb_target_pc       (btb_target_pc),
    .btb_pc_valid        (btb_pc_valid),
    .btb_pc_predictTaken (btb_pc_predictTaken),
    .ex_valid            (ex_valid),
    .ex_pc               (ex_pc),
    .ex_is_branch        (ex_is_branch),
    .ex_taken            (ex_taken),
    .ex_target           (ex_target),
    .ex_pred_taken       (ex_pred_taken),
    .ex_pred_target      (ex_pred_target),
    .jump_en             (jump_en),
    .pc_jump_addr        (pc_jump_addr),
    .branch_count        (branch_count),
    .mispredict_count    (mispredict_count)
  );

  // driver tasks
  task automatic drive_ex(input logic v, input logic [31:0] a, input logic br,
                          input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = a;
    ex_is_branch   = br;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // move to the next falling edge (one rising edge has passed)
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // checkers
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_lookup(input string tag, input logic [31:0] a, input logic v,
                            input logic tk, input logic [31:0] tgt);
    pc = a;
    #1;
    chk1({tag, "_valid"}, btb_pc_valid, v);
    chk1({tag, "_taken"}, btb_pc_predictTaken, tk);
    chk32({tag, "_target"}, btb_target_pc, tgt);
  endtask

  task automatic chk_redirect(input string tag, input logic je, input logic [31:0] addr);
    #1;
    chk1({tag, "_jump_en"}, jump_en, je);
    chk32({tag, "_jump_addr"}, pc_jump_addr, addr);
  endtask

  task automatic chk_counts(input string tag, input logic [31:0] bc, input logic [31:0] mc);
    chk32({tag, "_branch_count"}, branch_count, bc);
    chk32({tag, "_mispredict_count"}, mispredict_count, mc);
  endtask

  // directed sequence
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    pc  = 32'h100;
    idle_ex();

    // reset for two edges
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // cold miss
    idle_ex();
    chk_lookup("cold", 32'h100, 1'b0, 1'b0, 32'h104);
    chk_redirect("cold", 1'b0, 32'h0);
    chk_counts("cold", 32'd0, 32'd0);

    // allocate taken branch at 0x100; same-cycle lookup still misses
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
    chk_redirect("alloc", 1'b1, 32'h200);
    chk_lookup("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);

    next_cycle();
    idle_ex();
    chk_lookup("alloc_after", 32'h100, 1'b1, 1'b1, 32'h200);
    chk_counts("alloc_after", 32'd1, 32'd1);

    // two correctly predicted taken resolutions: ctr 10 -> 11 -> 11
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    chk_redirect("taken_ok1", 1'b0, 32'h0);
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1, 32'h200);
    chk_redirect("taken_ok2", 1'b0, 32'h0);

    // first not-taken: redirect to fall-through, ctr 11 -> 10
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    chk_redirect("nt1", 1'b1, 32'h104);
    next_cycle();
    idle_ex();
    chk_lookup("nt1_after", 32'h100, 1'b1, 1'b1, 32'h200);
    chk_counts("nt1_after", 32'd4, 32'd2);

    // second not-taken: ctr 10 -> 01, predicted not taken but still valid
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
    chk_redirect("nt2", 1'b1, 32'h104);
    next_cycle();
    idle_ex();
    chk_lookup("nt2_after", 32'h100, 1'b1, 1'b0, 32'h200);
    chk_counts("nt2_after", 32'd5, 32'd3);

    // target mismatch: taken to 0x300 with pred target 0x200
    next_cycle();
    drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
    chk_redirect("tgt_mis", 1'b1, 32'h300);
    chk_lookup("tgt_mis_same_cycle", 32'h100, 1'b1, 1'b0, 32'h200);
    next_cycle();
    idle_ex();
    chk_lookup("tgt_mis_after", 32'h100, 1'b1, 1'b1, 32'h300);
    chk_counts("tgt_mis_after", 32'd6, 32'd4);

    // aliasing: 0x140 shares index 0 with 0x100
    next_cycle();
    drive_ex(1'b1, 32'h140, 1'b1, 1'b1, 32'h400, 1'b0, 32'h144);
    chk_redirect("alias_alloc", 1'b1, 32'h400);
    next_cycle();
    idle_ex();
    chk_lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    chk_lookup("alias_new", 32'h140, 1'b1, 1'b1, 32'h400);
    chk_counts("alias_after", 32'd7, 32'd5);

    // non-branch predicted taken on the aliased entry: redirect and invalidate
    next_cycle();
    drive_ex(1'b1, 32'h140, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    chk_redirect("nonbr_stale", 1'b1, 32'h144);
    next_cycle();
    idle_ex();
    chk_lookup("nonbr_after", 32'h140, 1'b0, 1'b0, 32'h144);
    chk_counts("nonbr_after", 32'd7, 32'd6);

    // non-branch predicted not taken: nothing happens
    next_cycle();
    drive_ex(1'b1, 32'h148, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_redirect("nonbr_ok", 1'b0, 32'h0);

    // correctly predicted not-taken miss: no redirect despite odd pred target, no allocate
    next_cycle();
    drive_ex(1'b1, 32'h180, 1'b1, 1'b0, 32'h500, 1'b0, 32'h999);
    chk_redirect("nt_miss", 1'b0, 32'h0);
    next_cycle();
    idle_ex();
    chk_lookup("nt_miss_after", 32'h180, 1'b0, 1'b0, 32'h184);
    chk_counts("nt_miss_after", 32'd8, 32'd6);

    // ex_valid low with a would-be mispredict: ignored
    next_cycle();
    drive_ex(1'b0, 32'h1c0, 1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
    chk_redirect("ex_invalid", 1'b0, 32'h0);
    next_cycle();
    idle_ex();
    chk_lookup("ex_invalid_after", 32'h1c0, 1'b0, 1'b0, 32'h1c4);
    chk_counts("ex_invalid_after", 32'd8, 32'd6);

    // reset in the same cycle as a mispredict
    next_cycle();
    drive_ex(1'b1, 32'h200, 1'b1, 1'b1, 32'h700, 1'b0, 32'h0);
    rst = 1'b1;
    chk_redirect("rst_mis", 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    idle_ex();
    chk_counts("rst_after", 32'd0, 32'd0);
    chk_lookup("rst_after_alloc", 32'h200, 1'b0, 1'b0, 32'h204);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and branch-resolution unit that supplies and corrects the fetch stage's next-PC. Each cycle it looks up the current fetch `pc` and returns a predicted target with a taken hint (`btb_target_pc`, `btb_pc_valid`, `btb_pc_predictTaken`). When a branch resolves in execute, it trains its 2-bit counters. On a misprediction it drives the redirect pair (`jump_en`, `pc_jump_addr`) that the fetch stage muxes into its PC register.

## Interface
Parameters:
- `ENTRIES`, 16: BTB depth, direct-mapped, power of two ≥ 2; `IDX = log2(ENTRIES)`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc`  in  32  current fetch PC, lookup address.
- `btb_target_pc`  out  32  predicted target for `pc`.
- `btb_pc_valid`  out  1  `pc` hits a valid entry.
- `btb_pc_predictTaken`  out  1  hit and counter[1] = 1.
- `ex_valid`  in  1  execute stage holds a valid instruction this cycle.
- `ex_pc`  in  32  PC of that instruction.
- `ex_is_branch`  in  1  instruction is a branch or jump.
- `ex_taken`  in  1  resolved direction.
- `ex_target`  in  32  resolved taken target.
- `ex_pred_taken`  in  1  `btb_pc_predictTaken` captured at fetch, piped along.
- `ex_pred_target`  in  32  `btb_target_pc` captured at fetch, piped along.
- `jump_en`  out  1  redirect fetch this cycle; also the pipeline flush.
- `pc_jump_addr`  out  32  corrected next PC.
- `branch_count`  out  32  number of resolved branches.
- `mispredict_count`  out  32  number of redirects issued.

## Operation
- Storage per entry: `valid`, `tag` = pc[31:IDX+2], `target[31:0]`, `ctr[1:0]`.
- Index = pc[IDX+1:2].
- Lookup is combinational.
  - hit = valid[idx] && tag[idx] == pc[31:IDX+2].
  - On a miss: `btb_pc_valid` = 0, `btb_pc_predictTaken` = 0, `btb_target_pc` = pc + 4.
- Resolution is combinational when `ex_valid`:
  - Branch (`ex_is_branch` = 1) mispredicts if `ex_pred_taken != ex_taken`, or if `ex_taken && ex_pred_target != ex_target`.
  - Non-branch mispredicts if `ex_pred_taken` = 1 (stale/aliased entry).
  - `jump_en` = mispredict.
  - `pc_jump_addr` = (`ex_is_branch && ex_taken`) ? `ex_target` : `ex_pc` + 4.
  - When `jump_en` = 0, `pc_jump_addr` = 0.
- Update at the clock edge, only when `ex_valid`. "Hit" below means a hit on `ex_pc`.
  - Branch hit, taken: ctr saturating +1 (max 11), target ← `ex_target`.
  - Branch hit, not taken: ctr saturating −1 (min 00); target unchanged.
  - Branch miss, taken: allocate (overwrite) the entry with valid = 1, tag, target = `ex_target`, ctr = 10.
  - Branch miss, not taken: no write.
  - Non-branch with `ex_pred_taken` = 1 on a hit: clear valid[idx].
- Statistics:
  - `branch_count` +1 per `ex_valid && ex_is_branch`.
  - `mispredict_count` +1 per `jump_en`.
  - Both wrap modulo 2^32.

## Timing
- Lookup latency 0: outputs are valid in the same cycle as `pc`.
- Redirect latency 0: `jump_en` / `pc_jump_addr` are valid in the same cycle as the `ex_*` inputs. The fetch stage loads `pc_jump_addr` at the next edge.
- Table writes become visible to lookup the cycle after the update edge.
- Same-cycle lookup and update of the same index: lookup sees the old contents (no bypass).
- Reset (rst = 1 at an edge):
  - all `valid` ← 0, `ctr` ← 01, `tag` / `target` ← 0, both counters ← 0.
  - While rst is high, `jump_en` = 0 and no table or counter update occurs.
  - After reset every lookup misses: `btb_pc_valid` = 0, `btb_pc_predictTaken` = 0, `btb_target_pc` = pc + 4.
- Reset asserted mid-stream discards the in-flight update of that cycle.
- `ex_valid` = 0: no update, `jump_en` = 0, counters hold.
- Counter wrap: 32'hFFFF_FFFF + 1 → 0 with no flag.

## Test plan
- **Reset and cold miss.** Assert rst for 2 cycles, then pc = 0x100 → `btb_pc_valid` = 0, `btb_target_pc` = 0x104, `jump_en` = 0, both counts 0.
- **Allocate taken branch.** ex_pc = 0x100, branch, taken, target 0x200, pred_taken = 0 → `jump_en` = 1, `pc_jump_addr` = 0x200, mispredict_count = 1. Next cycle pc = 0x100 → valid = 1, predictTaken = 1 (ctr 10), target 0x200.
- **Counter saturation and decay.** Two more taken resolutions of 0x100 (predicted correctly) → `jump_en` = 0, ctr = 11. Then two not-taken → first gives `jump_en` = 1 with `pc_jump_addr` = 0x104, ctr 11→10. The second not-taken resolution, if presented with pred_taken = 1, also redirects to 0x104 and leaves ctr 10→01. After that, lookup predictTaken = 0 with valid = 1.
- **Target mismatch.** Hit entry at 0x100 with target 0x200; resolve taken to 0x300 with pred_target 0x200 → `jump_en` = 1, `pc_jump_addr` = 0x300, entry target becomes 0x300.
- **Aliasing / conflict.** ENTRIES = 16: allocate 0x100, then a taken branch at 0x140 (same index) → lookup 0x100 misses. A non-branch at 0x140 with pred_taken = 1 → `jump_en` = 1, `pc_jump_addr` = 0x144, entry invalidated.
- **Simultaneous events.** Lookup and update of the same index in one cycle → old lookup data. Reset asserted in the same cycle as a mispredict → `jump_en` = 0 and no count increment.
